// File: rtl/thread_issue_scheduler_pkg.sv
// Shared sizing and types for the thread issue scheduler; mirrors the
// scoreboard/thread definitions carried by npu_defines.sv.
package thread_issue_scheduler_pkg;

  localparam int unsigned THREAD_NUMB       = 8;
  localparam int unsigned SCOREBOARD_LENGTH = 32;
  localparam int unsigned THREAD_ID_W       = $clog2(THREAD_NUMB);

  typedef logic [SCOREBOARD_LENGTH-1:0] scoreboard_t;
  typedef logic [THREAD_ID_W-1:0]       thread_id_t;
  typedef logic [THREAD_NUMB-1:0]       thread_mask_t;

  // Thread index at distance 'off' after 'base', wrapping at THREAD_NUMB.
  function automatic thread_id_t rr_next(thread_id_t base, int unsigned off);
    int unsigned sum;
    sum = int'(base) + off;
    return thread_id_t'(sum % THREAD_NUMB);
  endfunction

endpackage

// File: rtl/thread_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter over per-thread requests; search starts one past the
// last granted thread. The pointer moves only on an enabled grant.
module rr_arbiter
  import thread_issue_scheduler_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  thread_mask_t request_i,
  output thread_mask_t grant_o,
  output thread_id_t   grant_id_o
);

  thread_id_t last_q;
  thread_id_t last_d;
  thread_id_t idx;
  logic       found;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 1; i <= THREAD_NUMB; i++) begin
      idx = rr_next(last_q, i);
      if (!found && request_i[idx]) begin
        found      = 1'b1;
        grant_id_o = idx;
      end
    end
    if (found && enable_i) begin
      grant_o[grant_id_o] = 1'b1;
    end
    last_d = (found && enable_i) ? grant_id_o : last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= thread_id_t'(THREAD_NUMB - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/thread_issue_scheduler.sv
// Per-thread register scoreboard plus round-robin issue of hazard-free heads.
// Define SCHEDULER_WAW_CHECK_EN to also stall on destination (WAW) hazards.
module thread_issue_scheduler
  import thread_issue_scheduler_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  thread_mask_t thread_en,
  input  thread_mask_t ib_valid,
  input  scoreboard_t  ib_source_mask        [THREAD_NUMB],
  input  scoreboard_t  ib_destination_mask   [THREAD_NUMB],
  output thread_mask_t ib_pop,
  input  logic         wb_valid,
  input  thread_id_t   wb_thread_id,
  input  scoreboard_t  wb_release_mask,
  input  thread_mask_t rollback_valid,
  input  scoreboard_t  rollback_clear_bitmap [THREAD_NUMB],
  output logic         is_instruction_valid,
  output thread_id_t   is_thread_id,
  output scoreboard_t  is_destination_mask,
  output scoreboard_t  scoreboard_busy       [THREAD_NUMB]
);

  thread_mask_t eligible;
  thread_mask_t grant;
  thread_id_t   grant_id;
  logic         any_grant;

  for (genvar t = 0; t < THREAD_NUMB; t++) begin : g_thread
    scoreboard_t dst_term;
    scoreboard_t wb_clr;
    scoreboard_t rb_clr;
    scoreboard_t iss_set;
    scoreboard_t sb_q;
    scoreboard_t sb_d;

`ifdef SCHEDULER_WAW_CHECK_EN
    assign dst_term = ib_destination_mask[t];
`else
    assign dst_term = '0;
`endif

    // A rolled-back thread is masked here so a squashed head never issues.
    assign eligible[t] = thread_en[t] && ib_valid[t] && !rollback_valid[t] &&
                         ((ib_source_mask[t] | dst_term) & sb_q) == '0;

    assign wb_clr  = (wb_valid && wb_thread_id == thread_id_t'(t)) ? wb_release_mask : '0;
    assign rb_clr  = rollback_valid[t] ? rollback_clear_bitmap[t] : '0;
    assign iss_set = ib_pop[t] ? ib_destination_mask[t] : '0;
    assign sb_d    = (sb_q & ~wb_clr & ~rb_clr) | iss_set;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sb_q <= '0;
      end else if (enable) begin
        sb_q <= sb_d;
      end
    end

    assign scoreboard_busy[t] = sb_q;
  end

  rr_arbiter u_arbiter (
    .clk_i      (clk),
    .rst_i      (reset),
    .enable_i   (enable),
    .request_i  (eligible),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign ib_pop    = grant;
  assign any_grant = |grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_instruction_valid <= 1'b0;
      is_thread_id         <= '0;
      is_destination_mask  <= '0;
    end else if (enable) begin
      is_instruction_valid <= any_grant;
      is_thread_id         <= any_grant ? grant_id : '0;
      is_destination_mask  <= any_grant ? ib_destination_mask[grant_id] : '0;
    end
  end

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed bench for thread_issue_scheduler: expected issues are queued by the
// stimulus and popped by a monitor whenever the issue register presents one.
module tb_thread_issue_scheduler;
  import thread_issue_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  thread_mask_t thread_en;
  thread_mask_t ib_valid;
  scoreboard_t  ib_src [THREAD_NUMB];
  scoreboard_t  ib_dst [THREAD_NUMB];
  thread_mask_t ib_pop;
  logic         wb_valid;
  thread_id_t   wb_tid;
  scoreboard_t  wb_mask;
  thread_mask_t rb_valid;
  scoreboard_t  rb_clr [THREAD_NUMB];
  logic         is_valid;
  thread_id_t   is_tid;
  scoreboard_t  is_dst;
  scoreboard_t  busy [THREAD_NUMB];

  int checks = 0;
  int errors = 0;
  logic en_prev;

  typedef struct {
    thread_id_t  tid;
    scoreboard_t dst;
  } exp_t;
  exp_t exp_q[$];

  thread_issue_scheduler dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .thread_en             (thread_en),
    .ib_valid              (ib_valid),
    .ib_source_mask        (ib_src),
    .ib_destination_mask   (ib_dst),
    .ib_pop                (ib_pop),
    .wb_valid              (wb_valid),
    .wb_thread_id          (wb_tid),
    .wb_release_mask       (wb_mask),
    .rollback_valid        (rb_valid),
    .rollback_clear_bitmap (rb_clr),
    .is_instruction_valid  (is_valid),
    .is_thread_id          (is_tid),
    .is_destination_mask   (is_dst),
    .scoreboard_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whether the edge that loaded the issue register was an enabled one.
  always @(posedge clk or posedge reset) begin
    if (reset) en_prev <= 1'b0;
    else       en_prev <= enable;
  end

  always @(negedge clk) begin
    if (!reset && en_prev && is_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got thread %0d dst 0x%0h expected none", is_tid, is_dst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("is_thread_id", 64'(is_tid), 64'(e.tid));
        chk("is_destination_mask", 64'(is_dst), 64'(e.dst));
      end
    end
  end

  task automatic step_start();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input thread_id_t t, input scoreboard_t d);
    exp_t e;
    thread_mask_t m;
    m = '0;
    m[t] = 1'b1;
    chk("ib_pop", 64'(ib_pop), 64'(m));
    e.tid = t;
    e.dst = d;
    exp_q.push_back(e);
  endtask

  task automatic nopop();
    chk("ib_pop_idle", 64'(ib_pop), 64'd0);
  endtask

  task automatic chk_busy(input int t, input scoreboard_t exp);
    chk($sformatf("busy[%0d]", t), 64'(busy[t]), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; thread_en = '0; ib_valid = '0;
    wb_valid = 1'b0; wb_tid = '0; wb_mask = '0; rb_valid = '0;
    for (int i = 0; i < THREAD_NUMB; i++) begin
      ib_src[i] = '0; ib_dst[i] = '0; rb_clr[i] = '0;
    end
    #12;
    chk("reset_is_valid", 64'(is_valid), 64'd0);
    chk("reset_is_tid", 64'(is_tid), 64'd0);
    for (int i = 0; i < THREAD_NUMB; i++) chk_busy(i, '0);
    reset = 1'b0;

    // First issue after reset goes to thread 0
    step_start(); thread_en = '1; ib_valid = 8'h01; ib_dst[0] = 32'h20;
    @(negedge clk); issue(0, 32'h20);
    step_start(); ib_valid = '0;
    @(negedge clk); nopop(); chk_busy(0, 32'h20);

    // RAW stall until writeback, no same-cycle bypass
    step_start(); ib_valid = 8'h01; ib_src[0] = 32'h20; ib_dst[0] = 32'h40;
    @(negedge clk); nopop();
    step_start(); @(negedge clk); nopop();
    step_start(); wb_valid = 1'b1; wb_tid = 0; wb_mask = 32'h20;
    @(negedge clk); nopop();
    step_start(); wb_valid = 1'b0;
    @(negedge clk); issue(0, 32'h40); chk_busy(0, '0);
    step_start(); ib_valid = '0; ib_src[0] = '0;
    @(negedge clk); chk_busy(0, 32'h40);
    step_start(); wb_valid = 1'b1; wb_tid = 0; wb_mask = 32'h40;
    step_start(); wb_valid = 1'b0;
    @(negedge clk); chk_busy(0, '0);

    // Reset in the middle of operation
    step_start(); ib_valid = 8'h01; ib_dst[0] = 32'h1;
    @(negedge clk); issue(0, 32'h1);
    step_start(); ib_valid = '0;
    @(negedge clk); #1 reset = 1'b1;
    #1;
    chk("midreset_is_valid", 64'(is_valid), 64'd0);
    chk("midreset_is_dst", 64'(is_dst), 64'd0);
    chk_busy(0, '0);
    #1 reset = 1'b0;

    // Full round-robin sweep with every thread eligible
    for (int i = 0; i < 16; i++) begin
      step_start(); ib_valid = 8'hFF;
      for (int k = 0; k < THREAD_NUMB; k++) ib_dst[k] = '0;
      @(negedge clk); issue(thread_id_t'(i % 8), '0);
    end
    step_start(); ib_valid = '0;

    // Rollback blocks the thread's grant; other threads still win
    step_start(); ib_valid = 8'h04; ib_dst[2] = 32'h200;
    @(negedge clk); issue(2, 32'h200);
    step_start(); ib_valid = 8'h0C; ib_dst[2] = 32'h400; ib_dst[3] = 32'h2;
    rb_valid = 8'h04; rb_clr[2] = 32'h200;
    @(negedge clk); issue(3, 32'h2); chk_busy(2, 32'h200);
    step_start(); rb_valid = '0; rb_clr[2] = '0; ib_valid = '0;
    @(negedge clk); chk_busy(2, '0); chk_busy(3, 32'h2);
    step_start(); wb_valid = 1'b1; wb_tid = 3; wb_mask = 32'h2;
    step_start(); wb_valid = 1'b0;

    // Writeback and new issue touching the same bit: set wins
    ib_valid = 8'h02; ib_dst[1] = 32'h8;
    @(negedge clk); issue(1, 32'h8);
    step_start(); ib_dst[1] = 32'h18; wb_valid = 1'b1; wb_tid = 1; wb_mask = 32'h8;
`ifdef SCHEDULER_WAW_CHECK_EN
    @(negedge clk); nopop();
    step_start(); wb_valid = 1'b0;
    @(negedge clk); issue(1, 32'h18); chk_busy(1, '0);
    step_start(); ib_valid = '0;
`else
    @(negedge clk); issue(1, 32'h18);
    step_start(); wb_valid = 1'b0; ib_valid = '0;
`endif
    @(negedge clk); chk_busy(1, 32'h18);
    step_start(); wb_valid = 1'b1; wb_tid = 1; wb_mask = 32'h18;
    step_start(); wb_valid = 1'b0;

    // Destination already busy, no source hazard
    ib_valid = 8'h10; ib_dst[4] = 32'h80;
    @(negedge clk); issue(4, 32'h80);
    step_start();
`ifdef SCHEDULER_WAW_CHECK_EN
    @(negedge clk); nopop();
`else
    @(negedge clk); issue(4, 32'h80);
`endif
    step_start(); ib_valid = '0;
    @(negedge clk); chk_busy(4, 32'h80);

    // Global stall holds state and ignores writeback
    step_start(); ib_valid = 8'h20; ib_dst[5] = 32'h1000;
    @(negedge clk); issue(5, 32'h1000);
    step_start(); enable = 1'b0; ib_dst[5] = 32'h2000;
    wb_valid = 1'b1; wb_tid = 4; wb_mask = 32'h80;
    @(negedge clk); nopop();
    step_start();
    @(negedge clk); nopop();
    chk("stall_is_valid", 64'(is_valid), 64'd1);
    chk("stall_is_tid", 64'(is_tid), 64'd5);
    chk("stall_is_dst", 64'(is_dst), 64'h1000);
    chk_busy(4, 32'h80); chk_busy(5, 32'h1000);
    step_start(); enable = 1'b1; wb_valid = 1'b0;
    @(negedge clk); issue(5, 32'h2000);
    step_start(); ib_valid = '0;
    @(negedge clk); chk_busy(5, 32'h3000);

    repeat (3) step_start();
    @(negedge clk);
    #1;
    chk("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_issue_scheduler.md
# thread_issue_scheduler

Per-thread scoreboard and round-robin issue arbiter that sits directly upstream of `rollback_handler`. Each cycle it picks one hazard-free thread from the instruction buffer heads. It marks that thread's destination registers busy and presents the issued instruction (`is_*`) to the operand fetch stage and the rollback handler. It consumes the handler's `rollback_valid` and `rollback_clear_bitmap` to release registers owned by flushed instructions, and it releases registers on writeback.

## Interface
- No parameters. Sized by `THREAD_NUMB` and `SCOREBOARD_LENGTH` from `npu_defines.sv`.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: global stall. When low, all state holds.
- `thread_en` in `thread_mask_t`: per-thread run enable.
- `ib_valid` in `thread_mask_t`: instruction-buffer head valid, per thread.
- `ib_source_mask` in `scoreboard_t [THREAD_NUMB]`: registers read by the head instruction.
- `ib_destination_mask` in `scoreboard_t [THREAD_NUMB]`: registers written by the head instruction.
- `ib_pop` out `thread_mask_t`: one-hot combinational grant (dequeue the head).
- `wb_valid` in 1: writeback valid.
- `wb_thread_id` in `thread_id_t`: writeback thread.
- `wb_release_mask` in `scoreboard_t`: registers written back.
- `rollback_valid` in `thread_mask_t`: from the rollback handler.
- `rollback_clear_bitmap` in `scoreboard_t [THREAD_NUMB]`: from the rollback handler.
- `is_instruction_valid` out 1: issued instruction valid. Registered; reset 0.
- `is_thread_id` out `thread_id_t`: issued thread. Registered; reset 0.
- `is_destination_mask` out `scoreboard_t`: issued destination mask. Registered; reset 0.
- `scoreboard_busy` out `scoreboard_t [THREAD_NUMB]`: current scoreboard. Reset all 0.

## Operation
- A thread t is eligible when all of the following hold: `thread_en[t]`, `ib_valid[t]`, `!rollback_valid[t]`, and `(ib_source_mask[t] | dst_term) & scoreboard_busy[t] == 0`. `dst_term` is defined under Configuration.
- Arbitration is round-robin among eligible threads, starting at `last_grant + 1` and wrapping at `THREAD_NUMB-1 -> 0`.
- `last_grant` resets to `THREAD_NUMB-1`, so thread 0 has first priority. It updates only on a grant.
- `ib_pop[t]` = grant & `enable`. At most one bit is set. It is all-zero when no thread is eligible or `enable` is low.
- Scoreboard next state for thread t: `(sb & ~wb_clr & ~rb_clr) | iss_set`.
  - `wb_clr` = `wb_release_mask` when `wb_valid` and `wb_thread_id==t`, else 0.
  - `rb_clr` = `rollback_clear_bitmap[t]` when `rollback_valid[t]`, else 0.
  - `iss_set` = `ib_destination_mask[t]` when `ib_pop[t]`, else 0.
- If the same bit is cleared and set in one cycle, the set wins. It belongs to a new instruction.
- Writeback to a bit that is not set is a no-op.
- Rollback of thread t blocks that thread's grant in the same cycle. No squashed issue leaves this block. Other threads remain grantable.
- Issue register loads `is_instruction_valid` <= |`ib_pop`, plus the thread ID and destination mask of the granted thread. When nothing is granted: valid is 0, ID and mask are 0.

## Timing
- Grant at cycle N. The scoreboard bit is visible at N+1, and `is_*` is valid at N+1.
- A rollback at N+1 for the thread issued at N clears that instruction's bits through `rollback_clear_bitmap`, because the handler includes `is_destination_mask`.
- A dependent instruction on the same thread can issue no earlier than the cycle after its writeback. Writeback and issue cannot bypass in the same cycle.
- `enable` low:
  - `ib_pop` = 0.
  - Scoreboard, `last_grant`, and `is_*` all hold.
  - Writeback and rollback inputs are ignored. Upstream stalls them under the same `enable`.
- Reset mid-operation: all scoreboards, `is_*`, and `last_grant` go asynchronously to their reset values. Pending instructions remain in the instruction buffer.

## Configuration
- `SCHEDULER_WAW_CHECK_EN` defined: `dst_term` = `ib_destination_mask[t]`, so the block stalls on WAW hazards.
- Undefined: `dst_term` = 0, so only RAW hazards stall. Destination bits are still set on issue.

## Structure
- `npu_defines.sv` already holds `scoreboard_t`, `thread_id_t`, `thread_mask_t`, `SCOREBOARD_LENGTH`, and `THREAD_NUMB`. No new package types are needed.
- One sub-module: `rr_arbiter`, with inputs request mask and enable, outputs one-hot grant and encoded ID, and an internal last-grant pointer.
- The scoreboard update and hazard check live in a generate loop per thread.

## Test plan
- Reset release, thread 0 valid with dst bit 5: `ib_pop`=0x01 at N; at N+1, `is_thread_id`=0, `is_destination_mask` bit 5, `scoreboard_busy[0]` bit 5.
- Thread 0 head reads bit 5 while it is busy: no pop until `wb_valid`, thread 0, mask bit 5; then pop in the next cycle.
- All 8 threads eligible and hazard-free for 16 cycles: grant order 0..7,0..7, exactly one pop per cycle.
- Thread 2 issues dst bit 9 at N; at N+1 `rollback_valid[2]`=1 with clear bit 9 and thread 2 eligible: no grant to thread 2 at N+1, bit 9 clear at N+2.
- Same-cycle writeback of bit 3 and new issue setting bit 3 on thread 1: bit 3 remains set.
- Head with dst bit 7 already busy and no source hazard: it issues when `SCHEDULER_WAW_CHECK_EN` is undefined, and stalls when it is defined.
